// File: rtl/tdp_ram_be_init.sv
// Single-clock true dual-port RAM with byte-lane writes, selectable read-during-write,
// optional output register, read-valid strobes, collision flag and post-reset clear.

module tdp_ram_rdpipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);
  logic [STAGES:0]             vld_pipe;
  logic [STAGES:1]             vld_q;
  logic [STAGES:0][DATA_W-1:0] dat_pipe;
  logic [STAGES:1][DATA_W-1:0] dat_q;

  assign vld_pipe = {vld_q, in_vld};
  assign dat_pipe = {dat_q, in_dat};

  // Data stages only advance with a valid beat, so the last stage holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      for (int s = 1; s <= STAGES; s++)
        if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
    end
  end

  assign dout   = dat_pipe[STAGES];
  assign rvalid = vld_pipe[STAGES];
endmodule

module tdp_ram_be_init #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dia,
  output logic [DATA_W-1:0]   doa,
  output logic                rvalida,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dib,
  output logic [DATA_W-1:0]   dob,
  output logic                rvalidb,
  output logic                init_busy,
  output logic                collision
);
  localparam int LANES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [LANES-1:0]  we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
  } req_t;

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RST_ST = (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              busy;

  req_t [1:0]              req;
  logic [1:0]              acc;
  logic [1:0][DATA_W-1:0]  old_w, fin_w, rd_dat, pdo;
  logic [1:0]              rd_vld, prv;

  assign req[0] = {ena, wea, addra, dia};
  assign req[1] = {enb, web, addrb, dib};
  assign busy   = (state == S_CLEAR);
  assign acc    = {req[1].en & ~busy, req[0].en & ~busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_ST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (busy) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && cnt == {ADDR_W{1'b1}}) state_nxt = S_READY;
  end

  // Port A is written last so it wins any lane both ports write at one address.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (acc[1] && req[1].we[l]) mem[req[1].addr][l*8 +: 8] <= req[1].di[l*8 +: 8];
        if (acc[0] && req[0].we[l]) mem[req[0].addr][l*8 +: 8] <= req[0].di[l*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign old_w[g] = mem[req[g].addr];

    // Final word at this port's address after both ports' lane writes resolve.
    always_comb begin
      fin_w[g] = old_w[g];
      for (int l = 0; l < LANES; l++) begin
        if (acc[0] && req[0].we[l] && req[0].addr == req[g].addr)
          fin_w[g][l*8 +: 8] = req[0].di[l*8 +: 8];
        else if (acc[1] && req[1].we[l] && req[1].addr == req[g].addr)
          fin_w[g][l*8 +: 8] = req[1].di[l*8 +: 8];
      end
    end

    assign rd_vld[g] = acc[g] && !(RDW_MODE == 2 && |req[g].we);
    assign rd_dat[g] = (RDW_MODE == 1 && |req[g].we) ? fin_w[g] : old_w[g];

    tdp_ram_rdpipe #(.DATA_W(DATA_W), .STAGES(OUT_REG + 1)) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (rd_vld[g]),
      .in_dat (rd_dat[g]),
      .dout   (pdo[g]),
      .rvalid (prv[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= &acc && (req[0].addr == req[1].addr) && (|req[0].we || |req[1].we);
  end

  assign doa       = pdo[0];
  assign dob       = pdo[1];
  assign rvalida   = prv[0];
  assign rvalidb   = prv[1];
  assign init_busy = busy;
endmodule
